// File: rtl/bc_pkg.sv
// Shared types and constants for the Bulls-and-Cows engine: FSM state,
// empty-digit marker and keypad helpers.
package bc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    SCORE = 2'd2,
    DONE  = 2'd3
  } bc_state_e;

  localparam logic [3:0] DIGIT_EMPTY = 4'hF;
  localparam int         NUM_KEYS    = 10;

  // Encodes a one-hot key vector; the highest set bit wins if more than one is set.
  function automatic logic [3:0] encode_key(input logic [NUM_KEYS-1:0] onehot);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      d = onehot[i] ? 4'(i) : d;
    end
    return d;
  endfunction

  function automatic logic multi_hot(input logic [NUM_KEYS-1:0] v);
    return (v & (v - {{(NUM_KEYS-1){1'b0}}, 1'b1})) != {NUM_KEYS{1'b0}};
  endfunction

endpackage

// File: rtl/bc_key_edge.sv
// Keypad front end: registers the raw key levels and emits one-cycle rising-edge
// strobes (encoded digit, multi-key error, clear, ok), all registered.
module bc_key_edge
  import bc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                key_clr,
  input  logic                key_ok,
  output logic                digit_valid,
  output logic [3:0]          digit,
  output logic                multi_err,
  output logic                clr_edge,
  output logic                ok_edge
);

  logic [NUM_KEYS-1:0] key_r;
  logic [NUM_KEYS-1:0] key_rise_s;
  logic                clr_r;
  logic                ok_r;
  logic                digit_valid_r;
  logic [3:0]          digit_r;
  logic                multi_err_r;
  logic                clr_edge_r;
  logic                ok_edge_r;

  assign key_rise_s = key & ~key_r;

  // Level history and registered edge strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_r         <= {NUM_KEYS{1'b0}};
      clr_r         <= 1'b0;
      ok_r          <= 1'b0;
      digit_valid_r <= 1'b0;
      digit_r       <= 4'd0;
      multi_err_r   <= 1'b0;
      clr_edge_r    <= 1'b0;
      ok_edge_r     <= 1'b0;
    end else begin
      key_r         <= key;
      clr_r         <= key_clr;
      ok_r          <= key_ok;
      digit_valid_r <= (key_rise_s != {NUM_KEYS{1'b0}}) && !multi_hot(key_rise_s);
      digit_r       <= encode_key(key_rise_s);
      multi_err_r   <= multi_hot(key_rise_s);
      clr_edge_r    <= key_clr & ~clr_r;
      ok_edge_r     <= key_ok & ~ok_r;
    end
  end

  assign digit_valid = digit_valid_r;
  assign digit       = digit_r;
  assign multi_err   = multi_err_r;
  assign clr_edge    = clr_edge_r;
  assign ok_edge     = ok_edge_r;

endmodule

// File: rtl/bulls_cows_engine.sv
// Parametrised Bulls-and-Cows engine: guess entry, sequential strike/ball scoring
// and attempt tracking. Define BC_DUP_REJECT_EN to reject repeated digits in a guess.
module bulls_cows_engine
  import bc_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MAX_TRIES  = 10,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] answer,
  input  logic [NUM_KEYS-1:0]     key,
  input  logic                    key_clr,
  input  logic                    key_ok,
  output logic [4*NUM_DIGITS-1:0] guess,
  output logic [CNT_W-1:0]        entry_cnt,
  output logic [CNT_W-1:0]        strike,
  output logic [CNT_W-1:0]        ball,
  output logic                    score_valid,
  output logic [7:0]              tries,
  output logic                    win,
  output logic                    lose,
  output logic                    busy,
  output logic                    key_err
);

  localparam logic [CNT_W-1:0] ZERO_CNT    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(NUM_DIGITS);
  localparam logic [7:0]       MAX_TRIES_C = 8'(MAX_TRIES);

  bc_state_e        state_r;
  bc_state_e        state_nx_s;
  logic [3:0]       ans_r   [NUM_DIGITS];
  logic [3:0]       guess_r [NUM_DIGITS];
  logic [CNT_W-1:0] entry_cnt_r;
  logic [CNT_W-1:0] idx_r;
  logic [CNT_W-1:0] strike_acc_r;
  logic [CNT_W-1:0] ball_acc_r;
  logic [CNT_W-1:0] strike_r;
  logic [CNT_W-1:0] ball_r;
  logic [7:0]       tries_r;
  logic [7:0]       tries_inc_s;
  logic             score_valid_r;
  logic             win_r;
  logic             lose_r;
  logic             key_err_r;
  logic             busy_s;

  logic             kv_digit_valid_s;
  logic [3:0]       kv_digit_s;
  logic             kv_multi_s;
  logic             kv_clr_s;
  logic             kv_ok_s;

  logic             act_digit_s;
  logic             act_clr_s;
  logic             act_err_s;
  logic             act_load_s;
  logic             act_step_s;
  logic             act_final_s;
  logic             final_win_s;
  logic             final_lose_s;
  logic             full_s;
  logic             dup_s;
  logic [CNT_W-1:0] last_idx_s;
  logic [3:0]       cur_guess_s;
  logic [3:0]       cur_ans_s;
  logic             hit_strike_s;
  logic             hit_ball_s;

  bc_key_edge u_key_edge (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .key_clr     (key_clr),
    .key_ok      (key_ok),
    .digit_valid (kv_digit_valid_s),
    .digit       (kv_digit_s),
    .multi_err   (kv_multi_s),
    .clr_edge    (kv_clr_s),
    .ok_edge     (kv_ok_s)
  );

  // Datapath decode: current score digit, ball search, duplicate check, try count.
  always_comb begin
    full_s      = (entry_cnt_r == FULL_CNT);
    last_idx_s  = entry_cnt_r - ONE_CNT;
    cur_guess_s = DIGIT_EMPTY;
    cur_ans_s   = 4'h0;
    hit_ball_s  = 1'b0;
    dup_s       = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur_guess_s = (CNT_W'(i) == idx_r) ? guess_r[i] : cur_guess_s;
      cur_ans_s   = (CNT_W'(i) == idx_r) ? ans_r[i]   : cur_ans_s;
    end
    for (int j = 0; j < NUM_DIGITS; j++) begin
      hit_ball_s = hit_ball_s | (ans_r[j] == cur_guess_s);
`ifdef BC_DUP_REJECT_EN
      // Empty slots hold F, which never matches a keyed digit, so the whole buffer can be searched.
      dup_s = dup_s | (guess_r[j] == kv_digit_s);
`else
      dup_s = 1'b0;
`endif
    end
    hit_strike_s = (cur_guess_s == cur_ans_s);
    tries_inc_s  = (tries_r == 8'hFF) ? 8'hFF : tries_r + 8'd1;
    final_win_s  = (strike_acc_r == FULL_CNT);
    final_lose_s = !final_win_s && (tries_inc_s == MAX_TRIES_C);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state and per-cycle actions; start overrides everything.
  always_comb begin
    state_nx_s  = state_r;
    act_digit_s = 1'b0;
    act_clr_s   = 1'b0;
    act_err_s   = 1'b0;
    act_load_s  = 1'b0;
    act_step_s  = 1'b0;
    act_final_s = 1'b0;
    if (start) begin
      state_nx_s = ENTRY;
    end else begin
      case (state_r)
        IDLE: state_nx_s = IDLE;
        ENTRY: begin
          if (kv_clr_s) begin
            act_clr_s = (entry_cnt_r != ZERO_CNT);
          end else if (kv_ok_s) begin
            if (full_s) begin
              state_nx_s = SCORE;
              act_load_s = 1'b1;
            end else begin
              act_err_s = 1'b1;
            end
          end else if (kv_multi_s) begin
            act_err_s = 1'b1;
          end else if (kv_digit_valid_s) begin
            if (full_s || dup_s) begin
              act_err_s = 1'b1;
            end else begin
              act_digit_s = 1'b1;
            end
          end else begin
            state_nx_s = ENTRY;
          end
        end
        SCORE: begin
          // idx_r == NUM_DIGITS is the extra cycle that publishes the result.
          if (idx_r == FULL_CNT) begin
            act_final_s = 1'b1;
            if (final_win_s || final_lose_s) begin
              state_nx_s = DONE;
            end else begin
              state_nx_s = ENTRY;
            end
          end else begin
            act_step_s = 1'b1;
          end
        end
        DONE:    state_nx_s = DONE;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    busy_s = (state_r == SCORE);
  end

  // Entry buffer, answer, scoring accumulators and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        ans_r[i]   <= 4'h0;
        guess_r[i] <= DIGIT_EMPTY;
      end
      entry_cnt_r   <= ZERO_CNT;
      idx_r         <= ZERO_CNT;
      strike_acc_r  <= ZERO_CNT;
      ball_acc_r    <= ZERO_CNT;
      strike_r      <= ZERO_CNT;
      ball_r        <= ZERO_CNT;
      tries_r       <= 8'd0;
      score_valid_r <= 1'b0;
      win_r         <= 1'b0;
      lose_r        <= 1'b0;
      key_err_r     <= 1'b0;
    end else if (start) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        ans_r[i]   <= answer[4*(NUM_DIGITS-1-i) +: 4];
        guess_r[i] <= DIGIT_EMPTY;
      end
      entry_cnt_r   <= ZERO_CNT;
      idx_r         <= ZERO_CNT;
      strike_acc_r  <= ZERO_CNT;
      ball_acc_r    <= ZERO_CNT;
      strike_r      <= ZERO_CNT;
      ball_r        <= ZERO_CNT;
      tries_r       <= 8'd0;
      score_valid_r <= 1'b0;
      win_r         <= 1'b0;
      lose_r        <= 1'b0;
      key_err_r     <= 1'b0;
    end else begin
      score_valid_r <= 1'b0;
      key_err_r     <= act_err_s;
      if (act_digit_s) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (CNT_W'(i) == entry_cnt_r) guess_r[i] <= kv_digit_s;
        end
        entry_cnt_r <= entry_cnt_r + ONE_CNT;
      end
      if (act_clr_s) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (CNT_W'(i) == last_idx_s) guess_r[i] <= DIGIT_EMPTY;
        end
        entry_cnt_r <= last_idx_s;
      end
      if (act_load_s) begin
        idx_r        <= ZERO_CNT;
        strike_acc_r <= ZERO_CNT;
        ball_acc_r   <= ZERO_CNT;
      end
      if (act_step_s) begin
        idx_r <= idx_r + ONE_CNT;
        if (hit_strike_s) begin
          strike_acc_r <= strike_acc_r + ONE_CNT;
        end else if (hit_ball_s) begin
          ball_acc_r <= ball_acc_r + ONE_CNT;
        end
      end
      if (act_final_s) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          guess_r[i] <= DIGIT_EMPTY;
        end
        entry_cnt_r   <= ZERO_CNT;
        strike_r      <= strike_acc_r;
        ball_r        <= ball_acc_r;
        tries_r       <= tries_inc_s;
        score_valid_r <= 1'b1;
        win_r         <= final_win_s;
        lose_r        <= final_lose_s;
      end
    end
  end

  // Pack the entry buffer with digit 0 in the most significant nibble.
  always_comb begin
    guess = {(4*NUM_DIGITS){1'b1}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      guess[4*(NUM_DIGITS-1-i) +: 4] = guess_r[i];
    end
  end

  assign entry_cnt   = entry_cnt_r;
  assign strike      = strike_r;
  assign ball        = ball_r;
  assign score_valid = score_valid_r;
  assign tries       = tries_r;
  assign win         = win_r;
  assign lose        = lose_r;
  assign busy        = busy_s;
  assign key_err     = key_err_r;

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Directed self-checking bench for bulls_cows_engine (NUM_DIGITS=4, MAX_TRIES=2).
module tb_bulls_cows_engine;

  localparam int ND = 4;
  localparam int MT = 2;
  localparam int CW = $clog2(ND + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   answer;
  logic [9:0]    key;
  logic          key_clr;
  logic          key_ok;
  logic [15:0]   guess;
  logic [CW-1:0] entry_cnt;
  logic [CW-1:0] strike;
  logic [CW-1:0] ball;
  logic          score_valid;
  logic [7:0]    tries;
  logic          win;
  logic          lose;
  logic          busy;
  logic          key_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        do_start;
    logic [15:0] ans;
    logic [15:0] gs;
    int          exp_strike;
    int          exp_ball;
    int          exp_win;
    int          exp_lose;
    int          exp_tries;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  bulls_cows_engine #(.NUM_DIGITS(ND), .MAX_TRIES(MT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .answer      (answer),
    .key         (key),
    .key_clr     (key_clr),
    .key_ok      (key_ok),
    .guess       (guess),
    .entry_cnt   (entry_cnt),
    .strike      (strike),
    .ball        (ball),
    .score_valid (score_valid),
    .tries       (tries),
    .win         (win),
    .lose        (lose),
    .busy        (busy),
    .key_err     (key_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One press-and-release of keys; returns key_err in the cycle after the update edge.
  task automatic press(input logic [9:0] k, input logic c, input logic o, output logic err);
    @(negedge clk);
    key = k; key_clr = c; key_ok = o;
    @(negedge clk);
    key = 10'd0; key_clr = 1'b0; key_ok = 1'b0;
    @(negedge clk);
    err = key_err;
  endtask

  task automatic press_digit(input logic [3:0] d, output logic err);
    logic [9:0] k;
    k = 10'd1 << d;
    press(k, 1'b0, 1'b0, err);
  endtask

  task automatic enter(input logic [15:0] g);
    logic e;
    for (int i = 0; i < 4; i++) begin
      press_digit(g[15-4*i -: 4], e);
    end
  endtask

  task automatic do_start(input logic [15:0] a);
    @(negedge clk);
    start = 1'b1; answer = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Raises key_ok and waits for score_valid; lat counts edges after the edge sampling ok.
  task automatic submit(output int lat, output logic busy_mid);
    int c;
    c = 0; lat = -1; busy_mid = 1'b0;
    @(negedge clk);
    key_ok = 1'b1;
    while (lat < 0 && c < 30) begin
      @(posedge clk); #1;
      c++;
      if (c == 2) busy_mid = busy;
      if (score_valid) lat = c - 1;
    end
  endtask

  task automatic watch(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (score_valid) cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat, cnt;
    logic bm, e;
    int   dup_err, dup_cnt;

    rst = 1'b1; start = 1'b0; answer = 16'h0; key = 10'd0; key_clr = 1'b0; key_ok = 1'b0;

    vecs[0] = '{1'b1, 16'h1234, 16'h1234, 4, 0, 1, 0, 1};
    vecs[1] = '{1'b1, 16'h1234, 16'h4321, 0, 4, 0, 0, 1};
    vecs[2] = '{1'b1, 16'h1234, 16'h1243, 2, 2, 0, 0, 1};
    vecs[3] = '{1'b1, 16'h9876, 16'h5678, 1, 2, 0, 0, 1};
    vecs[4] = '{1'b1, 16'h9012, 16'h0921, 0, 4, 0, 0, 1};
    vecs[5] = '{1'b0, 16'h9012, 16'h5678, 0, 0, 0, 1, 2};

    repeat (2) @(negedge clk);
    check("rst_guess", 32'(guess), 32'hFFFF);
    check("rst_entry_cnt", 32'(entry_cnt), 32'd0);
    check("rst_strike", 32'(strike), 32'd0);
    check("rst_ball", 32'(ball), 32'd0);
    check("rst_score_valid", 32'(score_valid), 32'd0);
    check("rst_tries", 32'(tries), 32'd0);
    check("rst_win_lose", 32'({win, lose}), 32'd0);
    check("rst_busy_err", 32'({busy, key_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    press_digit(4'd3, e);
    check("idle_key_err", 32'(e), 32'd0);
    check("idle_entry_cnt", 32'(entry_cnt), 32'd0);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].do_start) do_start(vecs[v].ans);
      enter(vecs[v].gs);
      check($sformatf("v%0d_guess", v), 32'(guess), 32'(vecs[v].gs));
      check($sformatf("v%0d_entry_cnt", v), 32'(entry_cnt), 32'd4);
      submit(lat, bm);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'd6);
      check($sformatf("v%0d_busy", v), 32'(bm), 32'd1);
      check($sformatf("v%0d_strike", v), 32'(strike), 32'(vecs[v].exp_strike));
      check($sformatf("v%0d_ball", v), 32'(ball), 32'(vecs[v].exp_ball));
      check($sformatf("v%0d_win", v), 32'(win), 32'(vecs[v].exp_win));
      check($sformatf("v%0d_lose", v), 32'(lose), 32'(vecs[v].exp_lose));
      check($sformatf("v%0d_tries", v), 32'(tries), 32'(vecs[v].exp_tries));
      check($sformatf("v%0d_guess_clr", v), 32'(guess), 32'hFFFF);
      check($sformatf("v%0d_cnt_clr", v), 32'(entry_cnt), 32'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_valid_pulse", v), 32'(score_valid), 32'd0);
      check($sformatf("v%0d_busy_end", v), 32'(busy), 32'd0);
      @(negedge clk);
      key_ok = 1'b0;
    end

    // Game lost: keys ignored in DONE until start.
    press_digit(4'd3, e);
    check("done_key_err", 32'(e), 32'd0);
    check("done_entry_cnt", 32'(entry_cnt), 32'd0);
    check("done_lose_sticky", 32'(lose), 32'd1);
    do_start(16'h1234);
    check("start_clears_lose", 32'(lose), 32'd0);
    check("start_clears_tries", 32'(tries), 32'd0);

    // 5,6,clr,7 then ok on a partial buffer.
    press_digit(4'd5, e);
    press_digit(4'd6, e);
    press(10'd0, 1'b1, 1'b0, e);
    press_digit(4'd7, e);
    check("clr_guess", 32'(guess), 32'h57FF);
    check("clr_entry_cnt", 32'(entry_cnt), 32'd2);
    press(10'd0, 1'b0, 1'b1, e);
    check("partial_ok_err", 32'(e), 32'd1);
    check("partial_ok_busy", 32'(busy), 32'd0);
    watch(10, cnt);
    check("partial_ok_no_score", 32'(cnt), 32'd0);

    // Two digit keys in one cycle.
    press(10'b00_0010_1000, 1'b0, 1'b0, e);
    check("multi_key_err", 32'(e), 32'd1);
    check("multi_entry_cnt", 32'(entry_cnt), 32'd2);
    check("multi_guess", 32'(guess), 32'h57FF);

    // Clear down to empty, then clear on empty is silent.
    press(10'd0, 1'b1, 1'b0, e);
    press(10'd0, 1'b1, 1'b0, e);
    check("clr_to_empty", 32'(guess), 32'hFFFF);
    press(10'd0, 1'b1, 1'b0, e);
    check("clr_empty_err", 32'(e), 32'd0);
    check("clr_empty_cnt", 32'(entry_cnt), 32'd0);

    // Digit and clr together: clr wins.
    press_digit(4'd1, e);
    press(10'b00_0000_0100, 1'b1, 1'b0, e);
    check("clr_wins_cnt", 32'(entry_cnt), 32'd0);
    check("clr_wins_guess", 32'(guess), 32'hFFFF);
    check("clr_wins_err", 32'(e), 32'd0);

    // Digit on a full buffer.
    enter(16'h1234);
    press_digit(4'd5, e);
    check("full_digit_err", 32'(e), 32'd1);
    check("full_digit_guess", 32'(guess), 32'h1234);

    // Duplicate digit handling.
`ifdef BC_DUP_REJECT_EN
    dup_err = 1; dup_cnt = 1;
`else
    dup_err = 0; dup_cnt = 2;
`endif
    do_start(16'h1234);
    press_digit(4'd1, e);
    press_digit(4'd1, e);
    check("dup_err", 32'(e), 32'(dup_err));
    check("dup_entry_cnt", 32'(entry_cnt), 32'(dup_cnt));

    // start during SCORE aborts without a score.
    do_start(16'h1234);
    enter(16'h1234);
    @(negedge clk);
    key_ok = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_entry_cnt", 32'(entry_cnt), 32'd0);
    @(negedge clk);
    start = 1'b0; key_ok = 1'b0;
    watch(10, cnt);
    check("abort_no_score", 32'(cnt), 32'd0);
    check("abort_tries", 32'(tries), 32'd0);
    press_digit(4'd7, e);
    check("abort_in_entry", 32'(guess), 32'h7FFF);

    // Asynchronous reset in the middle of scoring.
    press_digit(4'd2, e);
    press_digit(4'd3, e);
    press_digit(4'd4, e);
    check("pre_rst_guess", 32'(guess), 32'h7234);
    @(negedge clk);
    key_ok = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_guess", 32'(guess), 32'hFFFF);
    check("async_rst_cnt", 32'(entry_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0; key_ok = 1'b0;
    press_digit(4'd1, e);
    check("post_rst_idle", 32'(entry_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bulls_cows_engine.md
# bulls_cows_engine

Parametrised Bulls-and-Cows game engine. It replaces the fixed 4-digit game datapath with one configurable engine. Ten digit keys plus clear/submit enter a guess of `NUM_DIGITS` decimal digits. A sequential scorer produces strike/ball counts, and the engine tracks attempts up to a configurable limit, ending in win or lose. It sits between the keypad/debounce logic and the LCD/LED/piezo presentation blocks.

## Interface
Parameters:
- `NUM_DIGITS`, 4: digits per guess/answer; legal range 2..8.
- `MAX_TRIES`, 10: attempts allowed per game; legal range 1..255.
- `CNT_W`, `$clog2(NUM_DIGITS+1)`: width of the strike/ball counts (derived, do not override).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches `answer` and begins a game.
- `answer`  in  4*NUM_DIGITS  BCD answer; digit 0 is in the MS nibble.
- `key`  in  10  level-sensitive digit keys; bit d is digit d.
- `key_clr`  in  1  level; rising edge deletes the last entered digit.
- `key_ok`  in  1  level; rising edge submits the guess.
- `guess`  out  4*NUM_DIGITS  current entry buffer; digit 0 is in the MS nibble; unused nibbles are 4'hF.
- `entry_cnt`  out  CNT_W  number of digits entered.
- `strike`, `ball`  out  CNT_W each  last score.
- `score_valid`  out  1  one-cycle pulse when `strike`/`ball` update.
- `tries`  out  8  attempts scored in this game.
- `win`, `lose`  out  1 each  sticky until the next `start` or `rst`.
- `busy`  out  1  high while in SCORE.
- `key_err`  out  1  one-cycle pulse when a key event is rejected.

## Operation
- Key events are rising edges detected against a registered copy of the inputs.
- If more than one digit-key edge occurs in the same cycle, all of them are ignored and `key_err` pulses.
- FSM states:
  - IDLE → ENTRY on `start`.
  - ENTRY → SCORE on an ok edge when `entry_cnt == NUM_DIGITS`.
  - SCORE → ENTRY after NUM_DIGITS digits are processed, or SCORE → DONE.
  - DONE → ENTRY on `start`.
- `start` in any state restarts the game: it latches `answer`, fills the buffer with F, and clears `entry_cnt`, `tries`, `strike`, `ball`, `win` and `lose`.
- ENTRY behaviour:
  - A digit edge writes the digit at index `entry_cnt` and increments `entry_cnt`.
  - A digit edge when the buffer is full is rejected and pulses `key_err`.
  - A clr edge when `entry_cnt > 0` writes F to the last digit and decrements `entry_cnt`. A clr edge when `entry_cnt == 0` is ignored, with no error.
  - An ok edge when the buffer is not full is rejected and pulses `key_err`.
  - If a digit edge and a clr edge coincide, clr wins and the digit is dropped.
- SCORE behaviour:
  - Index i steps from 0 to NUM_DIGITS-1, one digit per cycle.
  - Strike accumulator increments if `guess[i] == ans[i]`.
  - Otherwise the ball accumulator increments if `guess[i]` equals any `ans[j]`.
  - All key edges are ignored while in SCORE.
- End of SCORE:
  - Register `strike` and `ball`, increment `tries` (saturating at 255), clear the buffer to F and set `entry_cnt` to 0.
  - If `strike == NUM_DIGITS`, set `win` and go to DONE.
  - Else if `tries == MAX_TRIES`, set `lose` and go to DONE.
  - Otherwise return to ENTRY.
- In IDLE and DONE, all keys are ignored and no `key_err` is produced.

## Timing
- Reset values: all outputs are 0 except `guess`, which resets to all-F. FSM resets to IDLE.
- Key latency: a key first sampled high at edge k updates `guess`/`entry_cnt` at edge k+1. `key_err` is high in the cycle after edge k+1.
- Score latency: an ok edge first sampled at edge k enters SCORE at edge k+1. Digits are processed at edges k+2 .. k+1+NUM_DIGITS. Outputs update and `score_valid` rises at edge k+2+NUM_DIGITS, and `score_valid` is high for exactly 1 cycle.
- `win`/`lose` assert in the same cycle as the final `score_valid`.
- `busy` is high from edge k+1 until edge k+2+NUM_DIGITS.
- A `start` during SCORE aborts scoring: no `score_valid` is issued, and the engine is in ENTRY at the next edge.
- `rst` takes effect immediately (asynchronous) in every state.

## Configuration
- `BC_DUP_REJECT_EN` defined: a digit edge whose digit already appears in `guess[0..entry_cnt-1]` is rejected, `key_err` pulses and the buffer is unchanged.
- `BC_DUP_REJECT_EN` undefined: duplicate digits are accepted. Scoring is unchanged; each guess digit still scores at most one strike or one ball.

## Structure
- Package `bc_pkg` holds:
  - the FSM state enum (IDLE, ENTRY, SCORE, DONE);
  - `DIGIT_EMPTY = 4'hF`;
  - key-count constant `NUM_KEYS = 10`.
- Sub-module `bc_key_edge`:
  - registers `key`, `key_clr` and `key_ok`;
  - outputs a digit-valid flag, the encoded 4-bit digit, a multi-key error flag, and clr/ok edge strobes.

## Test plan
- NUM_DIGITS=4, answer 16'h1234: enter 1,2,3,4, ok → `score_valid` 6 cycles after the ok edge, strike=4, ball=0, win=1, tries=1.
- Same answer: enter 4,3,2,1, ok → strike=0, ball=4, `guess` returns to 16'hFFFF, state ENTRY.
- Enter 5,6, clr, 7 → `guess` = 16'h57FF, `entry_cnt` = 2. Ok edge → `key_err` pulse, no score.
- Keys 3 and 5 pressed in the same cycle → `key_err` pulse, `entry_cnt` unchanged.
- MAX_TRIES=2: submit 5678 twice → second `score_valid` has strike=0, ball=0 with lose=1. Further keys are ignored until `start`.
- With `BC_DUP_REJECT_EN`: enter 1 then 1 → second key pulses `key_err`, `entry_cnt` = 1. Without the macro → `entry_cnt` = 2.
